// File: rtl/hamming_decoder.sv
// hamming_decoder: single-error-correcting decoder for 17-bit Hamming words.
// Two registered valid/ready stages feed corrected data and status downstream.
module hamming_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [0:16]      code_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [0:11]      data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err_corrected,
   output logic             err_uncorrectable,
   output logic [4:0]       syndrome,
   output logic [CNT_W-1:0] corr_count,
   output logic [CNT_W-1:0] uncorr_count,
   input  logic             clear_counts
);

   // Syndrome bit b is the parity of every index whose position (k+1)
   // has bit b set; position 16 only pairs with 17 for bit 4.
   function automatic logic [4:0] calc_syndrome(input logic [0:16] cw);
      logic [4:0] s;
      logic [4:0] pos;
      s = '0;
      for (int k = 0; k < 17; k++) begin
         pos = 5'(k + 1);
         for (int b = 0; b < 5; b++) begin
            if (pos[b]) begin
               s[b] = s[b] ^ cw[k];
            end
         end
      end
      return s;
   endfunction

   // Flip the single index addressed by an in-range syndrome.
   function automatic logic [0:16] correct(input logic [0:16] cw,
                                           input logic [4:0]  s);
      logic [0:16] c;
      c = cw;
      for (int k = 0; k < 17; k++) begin
         if (s == 5'(k + 1)) begin
            c[k] = ~cw[k];
         end
      end
      return c;
   endfunction

   // Data lives at every non-power-of-two position, in ascending order.
   function automatic logic [0:11] extract(input logic [0:16] cw);
      return {cw[2],  cw[4],  cw[5],  cw[6],
              cw[8],  cw[9],  cw[10], cw[11],
              cw[12], cw[13], cw[14], cw[16]};
   endfunction

   logic              s1_valid_q, s1_valid_d;
   logic [0:16]       s1_code_q, s1_code_d;
   logic [4:0]        s1_syn_q, s1_syn_d;

   logic              s2_valid_q, s2_valid_d;
   logic [0:11]       s2_data_q, s2_data_d;
   logic [4:0]        s2_syn_q, s2_syn_d;
   logic              s2_corr_q, s2_corr_d;
   logic              s2_uncorr_q, s2_uncorr_d;

   logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
   logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

   logic              s1_ready;
   logic              s2_ready;
   logic              in_fire;
   logic              s2_load;
   logic              out_fire;
   logic [0:16]       fixed_word;
   logic              s1_is_corr;
   logic              s1_is_uncorr;

   // A stage may take a new word when empty or when its word leaves now.
   assign s2_ready = !s2_valid_q || out_ready;
   assign s1_ready = !s1_valid_q || s2_ready;
   assign in_ready = s1_ready;
   assign in_fire  = in_valid && s1_ready;
   assign s2_load  = s1_valid_q && s2_ready;
   assign out_fire = s2_valid_q && out_ready;

   assign fixed_word   = correct(s1_code_q, s1_syn_q);
   assign s1_is_corr   = (s1_syn_q != 5'd0) && (s1_syn_q <= 5'd17);
   assign s1_is_uncorr = (s1_syn_q >= 5'd18);

   // Stage 1: capture the incoming word together with its syndrome.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_code_d  = s1_code_q;
      s1_syn_d   = s1_syn_q;
      if (s1_ready) begin
         s1_valid_d = in_valid;
      end
      if (in_fire) begin
         s1_code_d = code_in;
         s1_syn_d  = calc_syndrome(code_in);
      end
   end

   // Stage 2: correct, extract data and latch status; hold while stalled.
   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_data_d   = s2_data_q;
      s2_syn_d    = s2_syn_q;
      s2_corr_d   = s2_corr_q;
      s2_uncorr_d = s2_uncorr_q;
      if (s2_ready) begin
         s2_valid_d = s1_valid_q;
      end
      if (s2_load) begin
         s2_data_d   = extract(fixed_word);
         s2_syn_d    = s1_syn_q;
         s2_corr_d   = s1_is_corr;
         s2_uncorr_d = s1_is_uncorr;
      end
   end

   // Saturating counters bump on delivery; clear overrides any bump.
   always_comb begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (clear_counts) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end else if (out_fire) begin
         if (s2_corr_q && (corr_cnt_q != '1)) begin
            corr_cnt_d = corr_cnt_q + CNT_W'(1);
         end
         if (s2_uncorr_q && (uncorr_cnt_q != '1)) begin
            uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers; reset drops every word in flight.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_valid_q   <= 1'b0;
         s1_code_q    <= '0;
         s1_syn_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_data_q    <= '0;
         s2_syn_q     <= '0;
         s2_corr_q    <= 1'b0;
         s2_uncorr_q  <= 1'b0;
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_code_q    <= s1_code_d;
         s1_syn_q     <= s1_syn_d;
         s2_valid_q   <= s2_valid_d;
         s2_data_q    <= s2_data_d;
         s2_syn_q     <= s2_syn_d;
         s2_corr_q    <= s2_corr_d;
         s2_uncorr_q  <= s2_uncorr_d;
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

   assign out_valid         = s2_valid_q;
   assign data_out          = s2_data_q;
   assign syndrome          = s2_syn_q;
   assign err_corrected     = s2_corr_q;
   assign err_uncorrectable = s2_uncorr_q;
   assign corr_count        = corr_cnt_q;
   assign uncorr_count      = uncorr_cnt_q;

endmodule

// File: doc/hamming_decoder.md
Name: hamming_decoder

Overview:
- Receive-side stage directly downstream of the team's 12-in/17-out Hamming encoder.
- Accepts 17-bit codewords over a valid/ready handshake and computes the 5-bit syndrome.
- Corrects any single-bit error, extracts the 12 data bits and delivers them downstream through a 2-stage registered pipeline.
- Keeps saturating counts of corrected and uncorrectable words for status reporting.

Parameters:
CNT_W, 8, width of each error counter (saturating)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
code_in  input  [0:16]  codeword; index k is Hamming position k+1; parity at indices 0,1,3,7,15
in_valid  input  1  code_in valid
in_ready  output  1  stage 1 can accept this cycle
data_out  output  [0:11]  corrected data
out_valid  output  1  data_out/status valid
out_ready  input  1  downstream accepts
err_corrected  output  1  with out_valid: single error was corrected
err_uncorrectable  output  1  with out_valid: syndrome out of range, data uncorrected
syndrome  output  [4:0]  syndrome of the word on data_out
corr_count  output  [CNT_W-1:0]  count of delivered corrected words
uncorr_count  output  [CNT_W-1:0]  count of delivered uncorrectable words
clear_counts  input  1  synchronous clear of both counters

Behaviour:
- Reset (asynchronous, active-high): all pipeline valid flags cleared, data_out=0, syndrome=0, error flags=0, both counters=0. Asserting Reset mid-operation discards any words in flight. in_ready is 1 in the cycle after Reset deasserts.
- Syndrome:
  - s[b] = XOR of code_in[k] over all k with bit b of (k+1) set, for b=0..4.
  - s[4] covers indices 15,16 only.
- Stage 1 (accept): on in_valid && in_ready, register code_in and its syndrome; s1_valid=1.
- Stage 2 (correct):
  - s=0: no change.
  - 1 ≤ s ≤ 17: invert codeword index s-1 and set err_corrected. This includes flips of parity bits, where the data is unchanged but the flag is still set.
  - 18 ≤ s ≤ 31: no change; set err_uncorrectable.
  - Double errors that alias to s ≤ 17 are miscorrected silently (SEC only, by design).
- Data extraction: data_out[0..11] = corrected indices 2,4,5,6,8,9,10,11,12,13,14,16.
- Flow control:
  - s2_ready = !s2_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready.
  - No bubbles: with out_ready held at 1, one word per cycle; latency 2 cycles from input handshake to out_valid.
- Output hold: while out_valid && !out_ready, data_out, syndrome, flags and out_valid hold stable. No input word is dropped or duplicated.
- Counters:
  - Increment on output handshake (out_valid && out_ready) when the matching flag is set.
  - Saturate at all-ones.
  - clear_counts forces both counters to 0 next cycle and wins over a simultaneous increment.
- Flags and syndrome are meaningful only while out_valid=1. They are held from the last word otherwise.

Test Plan:
- Clean word: data 12'hA5C encoded, no flip, out_ready=1 -> 2 cycles later data_out=12'hA5C, syndrome=0, both flags 0, counters unchanged.
- Single-error sweep: for each index k=0..16, flip code_in[k] of the encoded 12'h3F1 -> data_out=12'h3F1, syndrome=k+1, err_corrected=1; corr_count reaches 17.
- Uncorrectable syndrome: flip indices 15 and 1 (positions 16 and 2, giving s=18) -> err_uncorrectable=1, data_out equals the raw extracted bits, uncorr_count increments by 1.
- Backpressure: stream 5 words back-to-back with out_ready low for cycles 3-6 -> in_ready drops once both stages are full, outputs hold stable, all 5 words emerge in order with none lost or duplicated.
- Saturation/clear: CNT_W=2, deliver 5 corrected words -> corr_count saturates at 3; assert clear_counts in the same cycle as a corrected handshake -> corr_count=0.
- Reset mid-stream: assert Reset with both stages valid -> out_valid=0, counters=0 immediately; the first word after release appears 2 cycles after its handshake.
